// File: rtl/fdsync_drain_pkg.sv
// Shared definitions for the fdsync_drain reader-side buffer.
package fdsync_drain_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefCntW  = 2;

  // Occupancy encodings; 2'd3 is never reached.
  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccTwo   = 2'd2
  } occ_e;

endpackage

// File: rtl/fdsync_drain_if.sv
// Producer/consumer bundle for fdsync_drain. The master side drives
// load/read/clear; the slave side (the buffer) returns data and status.
interface fdsync_drain_if #(
  parameter int unsigned WIDTH = fdsync_drain_pkg::DefWidth,
  parameter int unsigned CNTW  = fdsync_drain_pkg::DefCntW
);

  logic [WIDTH-1:0] d;
  logic             ld;
  logic             rd;
  logic             clr;
  logic [WIDTH-1:0] q;
  logic             qv;
  logic             full;
  logic [CNTW-1:0]  cnt;
  logic             ovr;
  logic             udr;

  modport master (
    output d, ld, rd, clr,
    input  q, qv, full, cnt, ovr, udr
  );

  modport slave (
    input  d, ld, rd, clr,
    output q, qv, full, cnt, ovr, udr
  );

endinterface

// File: rtl/fdsync_ent.sv
// One load-enabled storage entry with asynchronous active-low clear.
module fdsync_ent #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Capture d_i when enabled, otherwise hold.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fdsync_drain.sv
// Two-entry head/tail buffer between a single-cycle load strobe producer and
// a valid/read consumer. Head is shifted from tail on pop, so no pointers.
module fdsync_drain
  import fdsync_drain_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNTW  = DefCntW
) (
  input  logic          clk,
  input  logic          resetl,
  fdsync_drain_if.slave bus
);

  occ_e             cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic             udr_q, udr_d;
  logic             ovr_set, udr_set;
  logic             h_en, t_en;
  logic [WIDTH-1:0] h_din;
  logic [WIDTH-1:0] h_q, t_q;

  fdsync_ent #(
    .WIDTH(WIDTH)
  ) u_head (
    .clk    (clk),
    .resetl (resetl),
    .en_i   (h_en),
    .d_i    (h_din),
    .q_o    (h_q)
  );

  fdsync_ent #(
    .WIDTH(WIDTH)
  ) u_tail (
    .clk    (clk),
    .resetl (resetl),
    .en_i   (t_en),
    .d_i    (bus.d),
    .q_o    (t_q)
  );

  // Next-state decode: entry enables, head input mux, occupancy and flag sets.
  always_comb begin
    cnt_d   = cnt_q;
    h_en    = 1'b0;
    t_en    = 1'b0;
    h_din   = bus.d;
    ovr_set = 1'b0;
    udr_set = 1'b0;
    unique case (cnt_q)
      OccEmpty: begin
        udr_set = bus.rd;
        if (bus.ld) begin
          h_en  = 1'b1;
          cnt_d = OccOne;
        end
      end
      OccOne: begin
        if (bus.ld && !bus.rd) begin
          t_en  = 1'b1;
          cnt_d = OccTwo;
        end else if (bus.ld && bus.rd) begin
          // Pass-through: the popped head is replaced by the new word.
          h_en = 1'b1;
        end else if (bus.rd) begin
          h_en  = 1'b1;
          h_din = '0;
          cnt_d = OccEmpty;
        end
      end
      OccTwo: begin
        if (bus.rd) begin
          h_en  = 1'b1;
          h_din = t_q;
          t_en  = bus.ld;
          if (!bus.ld) begin
            cnt_d = OccOne;
          end
        end else begin
          // Full with no pop: the incoming word is dropped.
          ovr_set = bus.ld;
        end
      end
      default: begin
        cnt_d = OccEmpty;
      end
    endcase
  end

  // Sticky flags: a set on the same edge as clr takes priority.
  always_comb begin
    ovr_d = ovr_set | (ovr_q & ~bus.clr);
    udr_d = udr_set | (udr_q & ~bus.clr);
  end

  // Occupancy and flag registers.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      cnt_q <= OccEmpty;
      ovr_q <= 1'b0;
      udr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
      udr_q <= udr_d;
    end
  end

  assign bus.q    = h_q;
  assign bus.qv   = (cnt_q != OccEmpty);
  assign bus.full = (cnt_q == OccTwo);
  assign bus.cnt  = CNTW'(cnt_q);
  assign bus.ovr  = ovr_q;
  assign bus.udr  = udr_q;

endmodule

// File: tb/tb_fdsync_drain.sv
// Scoreboard bench for fdsync_drain: a queue-based reference model predicts
// the post-edge outputs, a negedge monitor pops and compares them.
module tb_fdsync_drain;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] q;
    logic         qv;
    logic         full;
    logic [1:0]   cnt;
    logic         ovr;
    logic         udr;
  } obs_t;

  logic clk = 1'b0;
  logic resetl = 1'b0;

  fdsync_drain_if #(.WIDTH(W), .CNTW(2)) bus ();

  fdsync_drain #(
    .WIDTH(W),
    .CNTW (2)
  ) dut (
    .clk    (clk),
    .resetl (resetl),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of at most two words plus two sticky flags.
  logic [W-1:0] mq[$];
  bit           movr;
  bit           mudr;
  obs_t         exp_q[$];
  int           n_chk = 0;
  int           n_pass = 0;

  function automatic obs_t model_obs();
    obs_t o;
    o.q    = (mq.size() > 0) ? mq[0] : '0;
    o.qv   = (mq.size() > 0);
    o.full = (mq.size() == 2);
    o.cnt  = 2'(mq.size());
    o.ovr  = movr;
    o.udr  = mudr;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.q    = bus.q;
    o.qv   = bus.qv;
    o.full = bus.full;
    o.cnt  = bus.cnt;
    o.ovr  = bus.ovr;
    o.udr  = bus.udr;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t req);
    n_chk++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got q=%h qv=%b full=%b cnt=%0d ovr=%b udr=%b, want q=%h qv=%b full=%b cnt=%0d ovr=%b udr=%b",
               name, $time, act.q, act.qv, act.full, act.cnt, act.ovr, act.udr,
               req.q, req.qv, req.full, req.cnt, req.ovr, req.udr);
    end
  endtask

  // Drive one cycle, advance the model, queue the expectation after the edge.
  task automatic step(input bit ld, input logic [W-1:0] d, input bit rd, input bit clr);
    int   pre;
    bit   uset;
    bit   oset;
    obs_t e;
    bus.ld  = ld;
    bus.d   = d;
    bus.rd  = rd;
    bus.clr = clr;
    pre  = mq.size();
    uset = rd && (pre == 0);
    oset = ld && !rd && (pre == 2);
    if (rd && pre > 0) void'(mq.pop_front());
    if (ld && !oset) mq.push_back(d);
    movr = oset | (movr & !clr);
    mudr = uset | (mudr & !clr);
    e = model_obs();
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    bus.ld  = 1'b0;
    bus.rd  = 1'b0;
    bus.clr = 1'b0;
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check("state", dut_obs(), exp_q.pop_front());
    end
  end

  initial begin
    obs_t zero;
    zero    = '0;
    bus.d   = '0;
    bus.ld  = 1'b0;
    bus.rd  = 1'b0;
    bus.clr = 1'b0;
    movr    = 1'b0;
    mudr    = 1'b0;
    #3;
    check("reset", dut_obs(), zero);
    #9;
    resetl = 1'b1;

    // Single-word latency.
    step(1, 16'hA5A5, 0, 0);
    step(0, '0, 1, 0);
    // Fill then drain in order.
    step(1, 16'h0001, 0, 0);
    step(1, 16'h0002, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    // Overrun, clear, and set-beats-clear.
    step(1, 16'h0001, 0, 0);
    step(1, 16'h0002, 0, 0);
    step(1, 16'h0003, 0, 0);
    step(0, '0, 0, 1);
    step(1, 16'h0004, 0, 1);
    step(0, '0, 0, 1);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    // Simultaneous load and read at one and two entries.
    step(1, 16'h0010, 0, 0);
    step(1, 16'h0020, 1, 0);
    step(0, '0, 1, 0);
    step(1, 16'h0030, 0, 0);
    step(1, 16'h0040, 0, 0);
    step(1, 16'h0050, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    // Underrun, alone and with a load.
    step(0, '0, 1, 0);
    step(1, 16'h7777, 1, 0);
    step(0, '0, 1, 1);

    // Asynchronous reset mid-operation, between clock edges.
    step(1, 16'h1111, 0, 0);
    step(1, 16'h2222, 0, 0);
    @(negedge clk);
    #1;
    resetl = 1'b0;
    #1;
    check("async_reset", dut_obs(), zero);
    mq.delete();
    movr = 1'b0;
    mudr = 1'b0;
    #1;
    resetl = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), 16'($urandom), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 10));
    end

    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
